// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice.
//   state_t        : responder FSM encoding (IDLE / BUSY / RESP)
//   CNT_W          : latency counter width (LAT up to 15)
//   BUS_W          : width of the byte address and data bus
//   FAULT_*        : fault reasons reported by fault_reason()
//   fault_reason() : classifies a byte address against the storage size
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int BUS_W = 16;

  localparam logic [1:0] FAULT_NONE      = 2'd0;
  localparam logic [1:0] FAULT_UNALIGNED = 2'd1;
  localparam logic [1:0] FAULT_RANGE     = 2'd2;

  // Bits above the word index (addr[15:addr_w+1]) must all be zero; bit 0
  // must be zero because only whole 16-bit words are addressable.
  function automatic logic [1:0] fault_reason(input logic [BUS_W-1:0] addr,
                                              input int addr_w);
    logic hi;
    hi = 1'b0;
    for (int i = 0; i < BUS_W; i++) begin
      if (i > addr_w) hi = hi | addr[i];
    end
    if (addr[0]) return FAULT_UNALIGNED;
    if (hi) return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request-response bus between the processor datapath and the
// memory responder.
//   req_valid/req_wr/req_addr/req_wdata : request from the initiator
//   ready                               : responder accepts this cycle
//   done/rdata/err                      : one-cycle response
// Modports: master = initiator side, slave = responder side.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic             req_valid;
  logic             req_wr;
  logic [BUS_W-1:0] req_addr;
  logic [BUS_W-1:0] req_wdata;
  logic             ready;
  logic             done;
  logic [BUS_W-1:0] rdata;
  logic             err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  ready, done, rdata, err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output ready, done, rdata, err
  );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Synchronous single-port word RAM, 2^ADDR_W x DATA_W.
//   clk   : clock
//   we    : write enable, writes wdata at addr on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read of addr (old contents on a write edge)
// Contents are not reset.
module mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle stalling data-memory responder. Accepts one request over a
// valid/ready handshake, waits LAT cycles, performs a 16-bit word access and
// returns a one-cycle done pulse with read data and a fault flag.
//   clk : clock
//   rst : synchronous active-low reset
//   bus : responder side of mem_responder_if (request in, response out)
// Parameters: ADDR_W word-address width, LAT busy cycles (1..15).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [BUS_W-1:0] addr_q;
  logic [BUS_W-1:0] wdata_q;
  logic             done_q;
  logic             err_q;
  logic             load_q;
  logic             fault;
  logic             access;
  logic             mem_we;
  logic [BUS_W-1:0] mem_rdata;

  assign fault  = (fault_reason(addr_q, ADDR_W) != FAULT_NONE);
  assign access = (state == BUSY) && (cnt == '0);
  // Gating with rst keeps an aborted store from reaching the array.
  assign mem_we = access && wr_q && !fault && rst;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (BUS_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[ADDR_W:1]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.req_valid) state_n = BUSY;
      BUSY:    if (cnt == '0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= access;
      err_q  <= access && fault;
      load_q <= access && !wr_q && !fault;
      if (state == IDLE && bus.req_valid) begin
        cnt <= CNT_W'(LAT - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Request capture is pure data; it only matters once the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      wr_q    <= bus.req_wr;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  // The array read register holds the word fetched at the access edge; it is
  // only exposed during the response cycle of a good load.
  assign bus.rdata = load_q ? mem_rdata : '0;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle, stalling data-memory responder: the target side of the processor's load/store interface, replacing the single-cycle memory model.
- Accepts one request at a time over a valid/ready handshake and waits a programmable latency.
- Performs a 16-bit word read or write, then returns a one-cycle done pulse with read data and an error flag.
- Sits between the processor datapath (initiator) and a word-organised storage array.

Parameters:
- ADDR_W, 10: word-address width; storage depth is 2^ADDR_W 16-bit words, byte-address space is 2^(ADDR_W+1) bytes.
- LAT, 2: busy cycles between acceptance and response; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  input  1  request present.
- req_wr  input  1  1 = store, 0 = load.
- req_addr  input  16  byte address.
- req_wdata  input  16  store data.
- ready  output  1  responder can accept a request this cycle.
- done  output  1  one-cycle response pulse.
- rdata  output  16  load data; valid only while done=1.
- err  output  1  request faulted; valid only while done=1.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; ready=1, done=0, rdata=0, err=0; latency counter=0.
  - Storage contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - ready=1.
  - If req_valid=1 at an edge: capture req_wr, req_addr and req_wdata; load counter with LAT-1; go to BUSY.
  - If req_valid=0: stay in IDLE.
- BUSY:
  - ready=0. Inputs are ignored; captured values are used.
  - If counter=0: perform the access at this edge and go to RESP.
  - Otherwise decrement the counter and stay in BUSY.
- RESP:
  - ready=0, done=1 for exactly one cycle.
  - Unconditionally return to IDLE at the next edge.
  - A req_valid held high during RESP is not accepted until IDLE.
- Timing:
  - Request accepted at edge n gives done=1 in the cycle between edges n+LAT and n+LAT+1.
  - ready returns high after edge n+LAT+1.
  - Minimum request-to-request spacing is LAT+2 cycles.
- Access at the BUSY-to-RESP edge:
  - Word index = addr[ADDR_W:1].
  - Load: rdata is registered from the array.
  - Store: the array word is written with wdata; rdata=0.
  - A load issued after a store to the same address returns the new data.
- Faults, checked on the captured address:
  - Fault conditions: addr[0]=1 (unaligned), or any of addr[15:ADDR_W+1] nonzero (out of range).
  - A faulting request still goes through the full LAT latency.
  - At RESP: err=1, rdata=0, and no array write occurs.
- done, err and rdata are registered outputs; ready is decoded from state.
- Outside RESP: rdata=0 and err=0.
- Reset mid-operation (in BUSY or RESP): the transaction is aborted, no write is committed, and no done is produced.
- Illegal state encoding: forced to IDLE on the next edge.
- Byte accesses are not supported.

Decomposition:
- Shared package contents:
  - FSM state encoding (2-bit: IDLE=0, BUSY=1, RESP=2).
  - Counter width constant (4).
  - Fault-reason constants (unaligned / out of range), for bench reporting.
- Sub-module mem_array:
  - Synchronous single-port 2^ADDR_W x 16 RAM.
  - Ports: clk, we, addr, wdata, rdata.
  - One-edge registered read; write on edge when we=1; no reset.
- mem_responder contains the FSM, capture registers, counter and fault check.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, release -> ready=1, done=0, rdata=0, err=0; with req_valid=0 for 10 cycles, no done pulse.
2. Store/load round trip, LAT=2: store 0xBEEF to 0x0010, then load 0x0010.
   - Each done pulse arrives exactly 2 cycles after its accepting edge.
   - Load returns rdata=0xBEEF with err=0.
   - ready is low for 3 cycles per transaction.
3. Unaligned store 0x1234 to 0x0011 -> done after LAT cycles with err=1, rdata=0; a following load of 0x0010 returns the prior value, unchanged.
4. Out-of-range load 0x0800 (ADDR_W=10) -> err=1, rdata=0; load 0x07FE -> err=0 with the stored top word.
5. Busy protection:
   - Hold req_valid=1 with changing addr/wdata through BUSY and RESP.
   - Only the first request is serviced; the next is accepted in the IDLE cycle after done.
   - Spacing is LAT+2 cycles.
6. Reset mid-op and LAT=1:
   - Store 0xAAAA to 0x0020, assert rst=0 during BUSY -> no done pulse; a later load of 0x0020 returns the old value.
   - With LAT=1, done occurs 1 cycle after acceptance.
